// File: rtl/cavlc_bitstream_packer_pkg.sv
// ----------------------------------------------------------------------------
// cavlc_bitstream_packer_pkg
// Shared definitions for the CAVLC bitstream packer: default widths and the
// packer FSM state encoding.
// ----------------------------------------------------------------------------
package cavlc_bitstream_packer_pkg;

    localparam int PKR_CODE_W = 16;   // max codeword width
    localparam int PKR_LEN_W  = 5;    // width of code_len
    localparam int PKR_ACC_W  = 32;   // packing accumulator width (>= 2*CODE_W)

    typedef enum logic [1:0] {
        PACK_RUN         = 2'd0,
        PACK_FLUSH_STOP  = 2'd1,
        PACK_FLUSH_DRAIN = 2'd2,
        PACK_DONE        = 2'd3
    } pack_state_e;

endpackage

// File: rtl/cavlc_bitstream_packer_epb.sv
// ----------------------------------------------------------------------------
// cavlc_bitstream_packer_epb
// Emulation-prevention stage on the packed byte stream (valid/ready in and
// out). Counts consecutive popped zero bytes; after two of them, a following
// byte <= 0x03 is held back and 0x03 is presented in its place. The held byte
// goes out on the next handshake. Only compiled when CAVLC_PACKER_EPB_EN is
// defined.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   in_valid_i/in_data_i   byte from the packer core
//   in_ready_o             core byte is consumed this cycle
//   out_valid_o/out_data_o byte towards the NAL FIFO
//   out_ready_i            downstream accepts byte
// ----------------------------------------------------------------------------
`ifdef CAVLC_PACKER_EPB_EN
module cavlc_bitstream_packer_epb (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i
);

    localparam logic [7:0] EPB_BYTE = 8'h03;

    logic [1:0] zrun_q, zrun_d;
    logic       insert;

    assign insert      = in_valid_i && (zrun_q == 2'd2) && (in_data_i <= EPB_BYTE);
    assign out_valid_o = in_valid_i;
    assign out_data_o  = insert ? EPB_BYTE : in_data_i;
    assign in_ready_o  = out_ready_i && !insert;

    always_comb begin
        zrun_d = zrun_q;
        if (out_valid_o && out_ready_i) begin
            if (insert) begin
                zrun_d = 2'd0;
            end else if (in_data_i == 8'h00) begin
                zrun_d = (zrun_q == 2'd3) ? 2'd3 : zrun_q + 2'd1;
            end else begin
                zrun_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zrun_q <= 2'd0;
        end else begin
            zrun_q <= zrun_d;
        end
    end

endmodule
`endif

// File: rtl/cavlc_bitstream_packer.sv
// ----------------------------------------------------------------------------
// cavlc_bitstream_packer
// Encoder-side bit writer. Packs right-aligned {code,len} codewords MSB-first
// into an RBSP byte stream and, on flush request, closes the NAL with
// rbsp_trailing_bits (stop bit + zero pad to a byte boundary) and drains.
// Optional emulation prevention: define CAVLC_PACKER_EPB_EN.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   code_valid_i       codeword present
//   code_ready_o       codeword accepted this cycle
//   code_bits_i        codeword, right-aligned (bit len-1 sent first)
//   code_len_i         codeword length 0..CODE_W (larger clamps + len_err)
//   flush_req_i        level request: stop bit + align + drain
//   flush_done_o       one-cycle pulse, flush complete
//   byte_valid_o/byte_data_o/byte_ready_i   output byte stream
//   bits_written_o     code bits accepted since reset / last flush_done
//   len_err_o          sticky oversize code_len seen
//
//   state            | meaning
//   PACK_RUN         | accepting codewords, popping full bytes
//   PACK_FLUSH_STOP  | waiting for room, then append '1' and pad to a byte
//   PACK_FLUSH_DRAIN | popping remaining bytes until accumulator empty
//   PACK_DONE        | flush_done pulse, clear bit counter
// ----------------------------------------------------------------------------
module cavlc_bitstream_packer
    import cavlc_bitstream_packer_pkg::*;
#(
    parameter int CODE_W = PKR_CODE_W,
    parameter int LEN_W  = PKR_LEN_W,
    parameter int ACC_W  = PKR_ACC_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    input  logic [CODE_W-1:0] code_bits_i,
    input  logic [LEN_W-1:0]  code_len_i,
    input  logic              flush_req_i,
    output logic              flush_done_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic [7:0]        byte_data_o,
    output logic [31:0]       bits_written_o,
    output logic              len_err_o
);

    localparam int FILL_W = $clog2(ACC_W + 1);

    pack_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_pop, code_ext, stop_bit;
    logic [FILL_W-1:0] fill_q, fill_d, fill_pop, place_sh;
    logic [31:0]       bits_q, bits_d;
    logic              len_err_q, len_err_d;
    logic [LEN_W-1:0]  len_eff;
    logic [CODE_W-1:0] code_mask;
    logic              accept, len_over;
    logic              core_valid, core_ready, core_pop;
    logic [7:0]        core_data;

    // ---------------- byte side ----------------
    assign core_valid = (fill_q >= FILL_W'(8));
    assign core_data  = acc_q[ACC_W-1 -: 8];
    assign core_pop   = core_valid && core_ready;

`ifdef CAVLC_PACKER_EPB_EN
    cavlc_bitstream_packer_epb u_epb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (core_valid),
        .in_data_i   (core_data),
        .in_ready_o  (core_ready),
        .out_valid_o (byte_valid_o),
        .out_data_o  (byte_data_o),
        .out_ready_i (byte_ready_i)
    );
`else
    assign byte_valid_o = core_valid;
    assign byte_data_o  = core_data;
    assign core_ready   = byte_ready_i;
`endif

    assign acc_pop  = core_pop ? (acc_q << 8) : acc_q;
    assign fill_pop = core_pop ? (fill_q - FILL_W'(8)) : fill_q;

    // ---------------- code side ----------------
    // Room check uses the current fill so ready never depends on this cycle's pop.
    assign code_ready_o = !reset_i && (state_q == PACK_RUN) && !flush_req_i &&
                          (fill_q <= FILL_W'(ACC_W - CODE_W));
    assign accept       = code_valid_i && code_ready_o;
    assign len_over     = (code_len_i > LEN_W'(CODE_W));
    assign len_eff      = len_over ? LEN_W'(CODE_W) : code_len_i;

    // At len == CODE_W the shift wraps to zero, so the minus one gives all ones.
    assign code_mask = code_bits_i & ((CODE_W'(1) << len_eff) - CODE_W'(1));
    // Lands the codeword MSB just below the bits still pending after any pop;
    // a zero-length code shifts by ACC_W and contributes nothing.
    assign place_sh  = FILL_W'(ACC_W) - fill_pop - FILL_W'(len_eff);
    assign code_ext  = ACC_W'(code_mask) << place_sh;
    assign stop_bit  = {1'b1, {(ACC_W-1){1'b0}}} >> fill_pop;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_pop;
        fill_d    = fill_pop;
        bits_d    = bits_q;
        len_err_d = len_err_q;
        case (state_q)
            PACK_RUN: begin
                if (accept) begin
                    acc_d     = acc_pop | code_ext;
                    fill_d    = fill_pop + FILL_W'(len_eff);
                    bits_d    = bits_q + 32'(len_eff);
                    len_err_d = len_err_q | len_over;
                end else if (flush_req_i) begin
                    state_d = PACK_FLUSH_STOP;
                end
            end
            PACK_FLUSH_STOP: begin
                if (fill_pop <= FILL_W'(ACC_W - 8)) begin
                    acc_d   = acc_pop | stop_bit;
                    // roundup8(fill + 1): an aligned fill still gains a whole 0x80 byte
                    fill_d  = (fill_pop + FILL_W'(8)) & ~FILL_W'(7);
                    state_d = PACK_FLUSH_DRAIN;
                end
            end
            PACK_FLUSH_DRAIN: begin
                if (fill_q == '0) begin
                    state_d = PACK_DONE;
                end
            end
            PACK_DONE: begin
                bits_d  = 32'd0;
                state_d = PACK_RUN;
            end
            default: state_d = PACK_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= PACK_RUN;
            acc_q     <= '0;
            fill_q    <= '0;
            bits_q    <= 32'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            bits_q    <= bits_d;
            len_err_q <= len_err_d;
        end
    end

    assign flush_done_o   = (state_q == PACK_DONE);
    assign bits_written_o = bits_q;
    assign len_err_o      = len_err_q;

endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// ----------------------------------------------------------------------------
// tb_cavlc_bitstream_packer
// Self-checking bench: expected bytes go into a scoreboard queue when a
// codeword/flush is driven; a monitor pops and compares every byte handshake.
// A vector table covers single-codeword + flush cases; hand sequences cover
// back-pressure, emulation prevention, oversize length and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_cavlc_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] code_bits;
    logic [4:0]  code_len;
    logic        flush_req;
    logic        flush_done;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [31:0] bits_written;
    logic        len_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cavlc_bitstream_packer dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .code_valid_i   (code_valid),
        .code_ready_o   (code_ready),
        .code_bits_i    (code_bits),
        .code_len_i     (code_len),
        .flush_req_i    (flush_req),
        .flush_done_o   (flush_done),
        .byte_valid_o   (byte_valid),
        .byte_ready_i   (byte_ready),
        .byte_data_o    (byte_data),
        .bits_written_o (bits_written),
        .len_err_o      (len_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples after the TB has driven at the falling edge.
    always @(negedge clk) begin
        #2;
        if (!reset && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual=%0h expected=none", byte_data);
            end else begin
                chk("byte", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send(input logic [15:0] c, input logic [4:0] l);
        int n = 0;
        code_bits  = c;
        code_len   = l;
        code_valid = 1'b1;
        while (!code_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic flush();
        int n = 0;
        flush_req = 1'b1;
        @(negedge clk);
        while (!flush_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done_seen", {31'd0, flush_done}, 32'd1);
        flush_req = 1'b0;
        @(negedge clk);
        chk("flush_done_pulse", {31'd0, flush_done}, 32'd0);
        chk("bits_after_flush", bits_written, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("drain_valid", {31'd0, byte_valid}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] code;
        logic [4:0]  len;
        int          nb;
        logic [23:0] bytes;   // expected bytes incl. trailing bits, first in [23:16]
        logic [31:0] bits;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0005, 5'd3,  1, 24'hB00000, 32'd3};
        vecs[1] = '{16'h00AB, 5'd8,  2, 24'hAB8000, 32'd8};
        vecs[2] = '{16'h0001, 5'd1,  1, 24'hC00000, 32'd1};
        vecs[3] = '{16'h0000, 5'd0,  1, 24'h800000, 32'd0};
        vecs[4] = '{16'hFFFF, 5'd16, 3, 24'hFFFF80, 32'd16};
        vecs[5] = '{16'h1234, 5'd13, 2, 24'h91A400, 32'd13};
        vecs[6] = '{16'h007F, 5'd7,  1, 24'hFF0000, 32'd7};
        vecs[7] = '{16'h0003, 5'd9,  2, 24'h01C000, 32'd9};

        reset      = 1'b1;
        code_valid = 1'b0;
        code_bits  = 16'd0;
        code_len   = 5'd0;
        flush_req  = 1'b0;
        byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_code_ready", {31'd0, code_ready}, 32'd0);
        chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_bits", bits_written, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, code_ready}, 32'd1);

        // Three codewords forming exactly one byte.
        exp_q.push_back(8'hA0);
        send(16'h1, 5'd1);
        send(16'h2, 5'd3);
        send(16'h0, 5'd4);
        chk("seq1_bits", bits_written, 32'd8);
        wait_drain();
        exp_q.push_back(8'h80);
        flush();
        wait_drain();

        // Single codeword then flush, table driven.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].nb; k++)
                exp_q.push_back(vecs[i].bytes[23 - 8*k -: 8]);
            send(vecs[i].code, vecs[i].len);
            chk($sformatf("vec%0d_bits", i), bits_written, vecs[i].bits);
            flush();
            wait_drain();
        end

        // Back-pressure: accumulator fills to 32 bits and holds.
        byte_ready = 1'b0;
        repeat (4) exp_q.push_back(8'hFF);
        send(16'hFFFF, 5'd16);
        send(16'hFFFF, 5'd16);
        chk("bp_ready_full", {31'd0, code_ready}, 32'd0);
        chk("bp_valid", {31'd0, byte_valid}, 32'd1);
        chk("bp_data", {24'd0, byte_data}, 32'hFF);
        repeat (3) begin
            @(negedge clk);
            chk("bp_data_stable", {24'd0, byte_data}, 32'hFF);
            chk("bp_ready_hold", {31'd0, code_ready}, 32'd0);
        end
        byte_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_fill24", {31'd0, code_ready}, 32'd0);
        @(negedge clk);
        chk("bp_ready_fill16", {31'd0, code_ready}, 32'd1);
        wait_drain();
        chk("bp_bits", bits_written, 32'd32);
        exp_q.push_back(8'h80);
        flush();
        wait_drain();

        // Two zero bytes followed by a small byte.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
`ifdef CAVLC_PACKER_EPB_EN
        exp_q.push_back(8'h03);
`endif
        exp_q.push_back(8'h01);
        send(16'h0000, 5'd16);
        send(16'h0001, 5'd8);
        wait_drain();
        chk("epb_bits", bits_written, 32'd24);
        exp_q.push_back(8'h80);
        flush();
        wait_drain();

        // Oversize length clamps to 16 bits and sets a sticky error.
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send(16'hFFFF, 5'd20);
        chk("len20_bits", bits_written, 32'd16);
        chk("len20_err", {31'd0, len_err}, 32'd1);
        flush();
        wait_drain();
        chk("len20_err_sticky", {31'd0, len_err}, 32'd1);

        // Reset with 12 bits pending drops them.
        byte_ready = 1'b0;
        send(16'h0ABC, 5'd12);
        chk("pre_rst_valid", {31'd0, byte_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, code_ready}, 32'd1);
        chk("post_rst_bits", bits_written, 32'd0);
        chk("post_rst_len_err", {31'd0, len_err}, 32'd0);
        byte_ready = 1'b1;
        exp_q.push_back(8'hC3);
        send(16'h00C3, 5'd8);
        wait_drain();
        exp_q.push_back(8'h80);
        flush();
        wait_drain();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
